// File: rtl/crg_pkg.sv
// crg_pkg: definitions shared by the clock/reset generation blocks.
//   crg_state_e : reset-sequencer state encoding (also exported as a debug value)
//   LOSS_W      : width of the saturating lock-loss counter
//   LOSS_MAX    : saturation value of that counter
package crg_pkg;

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } crg_state_e;

    localparam int LOSS_W = 8;
    localparam logic [LOSS_W-1:0] LOSS_MAX = {LOSS_W{1'b1}};

endpackage

// File: rtl/crg_rst_seq_if.sv
// crg_rst_seq_if: signal bundle between the reset sequencer and its environment.
//   master modport : environment side (drives LOCKED, SW_RESET, CH_MASK)
//   slave modport  : sequencer side (drives PLL_ARESET, RST_OUT, READY,
//                    LOSS_CNT, TIMEOUT, STATE_DBG)
// Signalling: every signal is a level, sampled on each rising INCLK edge;
// there is no valid/ready handshake. LOCKED may change at any time and is
// synchronized inside the sequencer; SW_RESET and CH_MASK must be synchronous
// to INCLK. All slave outputs are registered or decoded from registered state.
interface crg_rst_seq_if #(
    parameter int NUM_CH = 4
) ();
    import crg_pkg::*;

    logic              LOCKED;
    logic              SW_RESET;
    logic [NUM_CH-1:0] CH_MASK;
    logic              PLL_ARESET;
    logic [NUM_CH-1:0] RST_OUT;
    logic              READY;
    logic [LOSS_W-1:0] LOSS_CNT;
    logic              TIMEOUT;
    crg_state_e        STATE_DBG;

    modport master (
        output LOCKED, SW_RESET, CH_MASK,
        input  PLL_ARESET, RST_OUT, READY, LOSS_CNT, TIMEOUT, STATE_DBG
    );

    modport slave (
        input  LOCKED, SW_RESET, CH_MASK,
        output PLL_ARESET, RST_OUT, READY, LOSS_CNT, TIMEOUT, STATE_DBG
    );

endinterface

// File: rtl/crg_sync2.sv
// crg_sync2: two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronized output, two clk edges after d settles
module crg_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/crg_rst_seq.sv
// crg_rst_seq: PLL reset / lock-qualification / staggered channel reset release.
//   INCLK  : sole clock
//   ARESET : asynchronous active-high reset
//   bus    : crg_rst_seq_if slave (LOCKED, SW_RESET, CH_MASK in;
//            PLL_ARESET, RST_OUT, READY, LOSS_CNT, TIMEOUT, STATE_DBG out)
// Sequence: pulse PLL_ARESET, wait for LOCK_FILTER consecutive locked cycles
// (bounded by LOCK_TIMEOUT), then release channel k at k*STAGGER cycles into
// RELEASE, then RUN. Lock loss restarts from the PLL pulse; SW_RESET restarts
// from lock qualification.
module crg_rst_seq
    import crg_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 64,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STAGGER        = 8
) (
    input  logic         INCLK,
    input  logic         ARESET,
    crg_rst_seq_if.slave bus
);

    // Last RELEASE cycle index: the one in which the top channel deasserts.
    localparam int REL_END = (NUM_CH - 1) * STAGGER;

    localparam int PW = $clog2(PLL_RST_CYCLES + 1);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = $clog2(REL_END + 2);

    localparam logic [PW-1:0] PLL_LAST  = PW'(PLL_RST_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'(REL_END);

    crg_state_e        state;
    crg_state_e        next_state;
    logic              lock_s;
    logic [PW-1:0]     pll_cnt;
    logic [FW-1:0]     filt_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic [RW-1:0]     rel_cnt;
    logic [RW-1:0]     rel_d;
    logic [NUM_CH-1:0] rst_out_q;
    logic [NUM_CH-1:0] rst_out_d;
    logic [LOSS_W-1:0] loss_cnt_q;
    logic              timeout_q;
    logic              pll_areset;
    logic              ready;
    logic              lock_lost;
    logic              filt_done;
    logic              tmo_hit;

    crg_sync2 u_lock_sync (
        .clk (INCLK),
        .rst (ARESET),
        .d   (bus.LOCKED),
        .q   (lock_s)
    );

    // Lock only matters for loss accounting once channels may be released.
    assign lock_lost = ((state == S_RELEASE) || (state == S_RUN)) && !lock_s;
    // Filter completes on the cycle the count would reach LOCK_FILTER.
    assign filt_done = lock_s && (filt_cnt == FILT_LAST);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    // State register
    always_ff @(posedge INCLK or posedge ARESET) begin
        if (ARESET) begin
            state <= S_PLL_RST;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; lock loss is checked before SW_RESET so it wins.
    always_comb begin
        next_state = state;
        case (state)
            S_PLL_RST: begin
                if (pll_cnt == PLL_LAST) next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (filt_done)    next_state = S_RELEASE;
                else if (tmo_hit) next_state = S_PLL_RST;
            end
            S_RELEASE: begin
                if (!lock_s)                 next_state = S_PLL_RST;
                else if (bus.SW_RESET)       next_state = S_WAIT_LOCK;
                else if (rel_cnt == REL_LAST) next_state = S_RUN;
            end
            S_RUN: begin
                if (!lock_s)           next_state = S_PLL_RST;
                else if (bus.SW_RESET) next_state = S_WAIT_LOCK;
            end
            default: next_state = S_PLL_RST;
        endcase
    end

    // Every counter restarts from 0 on any entry into its state.
    assign rel_d = ((state == S_RELEASE) && (next_state == S_RELEASE)) ? rel_cnt + 1'b1 : '0;

    always_ff @(posedge INCLK or posedge ARESET) begin
        if (ARESET) begin
            pll_cnt  <= '0;
            filt_cnt <= '0;
            tmo_cnt  <= '0;
            rel_cnt  <= '0;
        end else begin
            pll_cnt <= ((state == S_PLL_RST) && (next_state == S_PLL_RST)) ? pll_cnt + 1'b1 : '0;
            if ((state == S_WAIT_LOCK) && (next_state == S_WAIT_LOCK)) begin
                filt_cnt <= lock_s ? filt_cnt + 1'b1 : '0;
                tmo_cnt  <= tmo_cnt + 1'b1;
            end else begin
                filt_cnt <= '0;
                tmo_cnt  <= '0;
            end
            rel_cnt <= rel_d;
        end
    end

    // Output decode. RST_OUT is computed from the upcoming state/count so that
    // the registered value changes on the very edge that enters RELEASE.
    always_comb begin
        pll_areset = (state == S_PLL_RST);
        ready      = (state == S_RUN);
        rst_out_d  = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            rst_out_d[k] = bus.CH_MASK[k] ||
                           !((next_state == S_RUN) ||
                             ((next_state == S_RELEASE) && (int'(rel_d) >= k * STAGGER)));
        end
    end

    always_ff @(posedge INCLK or posedge ARESET) begin
        if (ARESET) begin
            rst_out_q  <= '1;
            loss_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            rst_out_q <= rst_out_d;
            if (lock_lost && (loss_cnt_q != LOSS_MAX)) loss_cnt_q <= loss_cnt_q + 1'b1;
            if ((state == S_WAIT_LOCK) && (next_state == S_PLL_RST)) timeout_q <= 1'b1;
        end
    end

    assign bus.PLL_ARESET = pll_areset;
    assign bus.READY      = ready;
    assign bus.RST_OUT    = rst_out_q;
    assign bus.LOSS_CNT   = loss_cnt_q;
    assign bus.TIMEOUT    = timeout_q;
    assign bus.STATE_DBG  = state;

endmodule

// File: tb/tb_crg_rst_seq.sv
// tb_crg_rst_seq: self-checking bench for crg_rst_seq with a cycle-level
// behavioural model (phase + cycles-in-phase bookkeeping, lock history).
module tb_crg_rst_seq;
    import crg_pkg::*;

    localparam int NUM_CH = 3;
    localparam int PLL_N  = 8;
    localparam int FILT_N = 4;
    localparam int STAG   = 2;
    localparam int TMO_N  = 32;

    // model phases
    localparam int P_PLL  = 0;
    localparam int P_WAIT = 1;
    localparam int P_REL  = 2;
    localparam int P_RUN  = 3;

    logic INCLK  = 1'b0;
    logic ARESET = 1'b0;

    crg_rst_seq_if #(.NUM_CH(NUM_CH)) bus ();

    crg_rst_seq #(
        .NUM_CH         (NUM_CH),
        .PLL_RST_CYCLES (PLL_N),
        .LOCK_FILTER    (FILT_N),
        .LOCK_TIMEOUT   (TMO_N),
        .STAGGER        (STAG)
    ) dut (
        .INCLK  (INCLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    // ---------------- clock ----------------
    always #5 INCLK = ~INCLK;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_vec;
    int n_err;
    int cyc;

    int                m_phase;
    int                m_n;       // cycles spent in current phase
    int                m_lk_run;  // consecutive synchronized-lock cycles in WAIT
    bit                m_hist [2]; // [0] first sync stage, [1] synchronized lock
    int                m_loss;
    bit                m_tmo;
    logic [NUM_CH-1:0] m_rst;

    bit                r_lk;
    bit                r_sw;
    logic [NUM_CH-1:0] r_mask;
    bit                seen_low;
    bit                repulse;
    int                w;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_PLL;
        m_n       = 0;
        m_lk_run  = 0;
        m_hist[0] = 1'b0;
        m_hist[1] = 1'b0;
        m_loss    = 0;
        m_tmo     = 1'b0;
        m_rst     = '1;
    endtask

    task automatic model_step(input bit lk, input bit sw, input logic [NUM_CH-1:0] mask);
        bit ls;
        ls        = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = lk;
        case (m_phase)
            P_PLL: begin
                m_n++;
                if (m_n == PLL_N) begin
                    m_phase  = P_WAIT;
                    m_n      = 0;
                    m_lk_run = 0;
                end
            end
            P_WAIT: begin
                m_lk_run = ls ? m_lk_run + 1 : 0;
                m_n++;
                if (m_lk_run == FILT_N) begin
                    m_phase = P_REL;
                    m_n     = 0;
                end else if (m_n == TMO_N) begin
                    m_phase = P_PLL;
                    m_n     = 0;
                    m_tmo   = 1'b1;
                end
            end
            default: begin
                if (!ls) begin
                    if (m_loss < 255) m_loss++;
                    m_phase = P_PLL;
                    m_n     = 0;
                end else if (sw) begin
                    m_phase  = P_WAIT;
                    m_n      = 0;
                    m_lk_run = 0;
                end else if (m_phase == P_REL) begin
                    if (m_n == (NUM_CH - 1) * STAG) begin
                        m_phase = P_RUN;
                        m_n     = 0;
                    end else begin
                        m_n++;
                    end
                end
            end
        endcase
        for (int k = 0; k < NUM_CH; k++)
            m_rst[k] = mask[k] | !((m_phase == P_RUN) || ((m_phase == P_REL) && (m_n >= k * STAG)));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit lk, input bit sw, input logic [NUM_CH-1:0] mask);
        bus.LOCKED   = lk;
        bus.SW_RESET = sw;
        bus.CH_MASK  = mask;
    endtask

    task automatic compare_outputs();
        check_eq("pll_areset", {31'b0, bus.PLL_ARESET}, {31'b0, m_phase == P_PLL});
        check_eq("ready", {31'b0, bus.READY}, {31'b0, m_phase == P_RUN});
        check_eq("rst_out", 32'(bus.RST_OUT), 32'(m_rst));
        check_eq("loss_cnt", 32'(bus.LOSS_CNT), m_loss);
        check_eq("timeout", {31'b0, bus.TIMEOUT}, {31'b0, m_tmo});
    endtask

    // One clock: capture what the DUT will sample, advance, check just after the edge.
    task automatic tick();
        bit                lk;
        bit                sw;
        logic [NUM_CH-1:0] mask;
        lk   = bus.LOCKED;
        sw   = bus.SW_RESET;
        mask = bus.CH_MASK;
        @(posedge INCLK);
        #1;
        cyc++;
        if (ARESET) model_reset();
        else        model_step(lk, sw, mask);
        compare_outputs();
    endtask

    task automatic apply_reset();
        ARESET = 1'b0;
        #1;
        ARESET = 1'b1;
        #1;
        check_eq("reset pll_areset", {31'b0, bus.PLL_ARESET}, 32'd1);
        check_eq("reset ready", {31'b0, bus.READY}, 32'd0);
        check_eq("reset rst_out", 32'(bus.RST_OUT), 32'h7);
        check_eq("reset loss_cnt", 32'(bus.LOSS_CNT), 32'd0);
        check_eq("reset timeout", {31'b0, bus.TIMEOUT}, 32'd0);
        model_reset();
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int i;
        i = 0;
        while (bus.READY !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
        check_eq({tag, " ready reached"}, {31'b0, bus.READY}, 32'd1);
    endtask

    // Reset, hold LOCKED high and time every edge of the release sequence.
    task automatic run_release(input logic [NUM_CH-1:0] mask, input string tag);
        int t_pll;
        int t_rdy;
        int t_r [NUM_CH];
        int base;
        t_pll = -1;
        t_rdy = -1;
        foreach (t_r[k]) t_r[k] = -1;
        drive(1'b1, 1'b0, mask);
        apply_reset();
        for (int i = 1; i <= PLL_N + FILT_N + (NUM_CH - 1) * STAG + 10; i++) begin
            tick();
            if (t_pll < 0 && bus.PLL_ARESET === 1'b0) t_pll = i;
            for (int k = 0; k < NUM_CH; k++)
                if (t_r[k] < 0 && bus.RST_OUT[k] === 1'b0) t_r[k] = i;
            if (t_rdy < 0 && bus.READY === 1'b1) t_rdy = i;
        end
        base = PLL_N + FILT_N;
        check_eq({tag, " pll_pulse_len"}, t_pll, PLL_N);
        for (int k = 0; k < NUM_CH; k++)
            check_eq($sformatf("%s rst_out[%0d] fall", tag, k), t_r[k], mask[k] ? -1 : base + k * STAG);
        check_eq({tag, " ready_rise"}, t_rdy, base + (NUM_CH - 1) * STAG + 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        drive(1'b1, 1'b0, '0);

        // normal bring-up and masked bring-up
        run_release(3'b000, "normal");
        run_release(3'b010, "mask010");

        // SW_RESET alone in RUN: back to lock qualification, no PLL pulse
        drive(1'b1, 1'b1, '0);
        tick();
        drive(1'b1, 1'b0, '0);
        check_eq("sw ready drop", {31'b0, bus.READY}, 32'd0);
        check_eq("sw no pll pulse", {31'b0, bus.PLL_ARESET}, 32'd0);
        check_eq("sw rst_out", 32'(bus.RST_OUT), 32'h7);
        wait_ready(40, "after sw");
        check_eq("sw loss unchanged", 32'(bus.LOSS_CNT), 32'd0);

        // lock loss and SW_RESET at the same decision edge: lock loss wins
        drive(1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b1, '0);
        tick();
        drive(1'b1, 1'b0, '0);
        check_eq("combo pll_areset", {31'b0, bus.PLL_ARESET}, 32'd1);
        check_eq("combo loss_cnt", 32'(bus.LOSS_CNT), 32'd1);
        check_eq("combo rst_out", 32'(bus.RST_OUT), 32'h7);
        wait_ready(60, "after combo");

        // randomized traffic against the model
        r_mask = '0;
        for (int i = 0; i < 1500; i++) begin
            r_lk = ($urandom_range(0, 24) != 0);
            r_sw = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 63) == 0) r_mask = NUM_CH'($urandom_range(0, 7));
            drive(r_lk, r_sw, r_mask);
            tick();
        end

        // lock glitching low one cycle in three: filter never completes
        drive(1'b1, 1'b0, '0);
        apply_reset();
        seen_low = 1'b0;
        repulse  = 1'b0;
        for (int i = 0; i < PLL_N + TMO_N + 24; i++) begin
            drive((i % 3) != 2, 1'b0, '0);
            tick();
            if (bus.PLL_ARESET === 1'b0) seen_low = 1'b1;
            else if (seen_low) repulse = 1'b1;
        end
        check_eq("glitch timeout flag", {31'b0, bus.TIMEOUT}, 32'd1);
        check_eq("glitch pll re-pulse", {31'b0, repulse}, 32'd1);

        // asynchronous reset in the middle of RELEASE
        drive(1'b1, 1'b0, '0);
        apply_reset();
        w = 0;
        while (bus.RST_OUT[0] !== 1'b0 && w < 40) begin
            tick();
            w++;
        end
        check_eq("mid release reached", {31'b0, bus.RST_OUT[0]}, 32'd0);
        check_eq("mid release not ready", {31'b0, bus.READY}, 32'd0);
        #2;
        ARESET = 1'b1;
        #1;
        check_eq("abort pll_areset", {31'b0, bus.PLL_ARESET}, 32'd1);
        check_eq("abort ready", {31'b0, bus.READY}, 32'd0);
        check_eq("abort rst_out", 32'(bus.RST_OUT), 32'h7);
        check_eq("abort timeout", {31'b0, bus.TIMEOUT}, 32'd0);
        model_reset();
        run_release(3'b000, "after abort");

        // repeated lock loss in RUN: all channels back in reset, counter saturates
        for (int d = 0; d < 300; d++) begin
            wait_ready(60, "drop loop");
            drive(1'b0, 1'b0, '0);
            tick();
            drive(1'b1, 1'b0, '0);
            tick();
            check_eq("drop ready held", {31'b0, bus.READY}, 32'd1);
            tick();
            check_eq("drop rst_out", 32'(bus.RST_OUT), 32'h7);
        end
        check_eq("loss saturated", 32'(bus.LOSS_CNT), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
